morse_letter_decoder: RTL and testbench

Parametrised receive-side decoder for the Morse link. Accepts the 2-bit symbol stream recovered from the channel (dit, dah, end-of-letter, and a new end-of-word symbol), assembles symbols into a code pattern, and translates completed patterns to 6-bit letter codes. Decoded letters are buffered in an output FIFO with a valid/ready handshake, so downstream logic can stall without losing characters. Malformed patterns and buffer overruns are flagged.

---
 rtl/morse_pkg.sv | 18 +
 rtl/morse_letter_decoder_if.sv | 21 ++
 rtl/morse_lut.sv | 59 +++++
 rtl/morse_letter_decoder.sv | 113 +++++++++++
 tb/tb_morse_letter_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared symbol/letter constants, assembler state and push record for the
// Morse receive-side letter decoder.
package morse_pkg;
  localparam logic [1:0] SYM_DIT = 2'b00;
  localparam logic [1:0] SYM_DAH = 2'b11;
  localparam logic [1:0] SYM_EOL = 2'b01;
  localparam logic [1:0] SYM_EOW = 2'b10;

  localparam logic [5:0] LETTER_SPACE   = 6'd36;
  localparam logic [5:0] LETTER_INVALID = 6'd63;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_SPACE_PEND} state_t;

  typedef struct packed {
    logic       vld;
    logic [5:0] code;
  } push_t;
endpackage

// File: rtl/morse_letter_decoder_if.sv
// Symbol input stream, letter output stream and status flags of the decoder.
interface morse_letter_decoder_if #(parameter int DEPTH = 4);
  logic                   sym_valid;
  logic                   sym_ready;
  logic [1:0]             sym;
  logic                   letter_valid;
  logic                   letter_ready;
  logic [5:0]             letter;
  logic [$clog2(DEPTH):0] level;
  logic                   err_code;
  logic                   err_drop;

  modport master (
    output sym_valid, sym, letter_ready,
    input  sym_ready, letter_valid, letter, level, err_code, err_drop
  );
  modport slave (
    input  sym_valid, sym, letter_ready,
    output sym_ready, letter_valid, letter, level, err_code, err_drop
  );
endinterface

// File: rtl/morse_lut.sv
// Combinational (len, pattern) -> letter code table. Pattern is right-aligned,
// first symbol in the highest occupied bit, 1 = dah.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMS = 6,
  localparam int LW = $clog2(MAX_SYMS + 1)
) (
  input  logic [LW-1:0]       len,
  input  logic [MAX_SYMS-1:0] pattern,
  output logic [5:0]          letter
);
  always_comb begin
    letter = LETTER_INVALID;
    // Nothing in the alphabet is longer than five symbols.
    if (len != '0 && len <= LW'(5) && (pattern >> 5) == '0) begin
      case ({len[2:0], pattern[4:0]})
        8'b001_00000: letter = 6'd4;
        8'b001_00001: letter = 6'd19;
        8'b010_00001: letter = 6'd0;
        8'b010_00000: letter = 6'd8;
        8'b010_00011: letter = 6'd12;
        8'b010_00010: letter = 6'd13;
        8'b011_00100: letter = 6'd3;
        8'b011_00110: letter = 6'd6;
        8'b011_00101: letter = 6'd10;
        8'b011_00111: letter = 6'd14;
        8'b011_00010: letter = 6'd17;
        8'b011_00000: letter = 6'd18;
        8'b011_00001: letter = 6'd20;
        8'b011_00011: letter = 6'd22;
        8'b100_01000: letter = 6'd1;
        8'b100_01010: letter = 6'd2;
        8'b100_00010: letter = 6'd5;
        8'b100_00000: letter = 6'd7;
        8'b100_00111: letter = 6'd9;
        8'b100_00100: letter = 6'd11;
        8'b100_00110: letter = 6'd15;
        8'b100_01101: letter = 6'd16;
        8'b100_00001: letter = 6'd21;
        8'b100_01001: letter = 6'd23;
        8'b100_01011: letter = 6'd24;
        8'b100_01100: letter = 6'd25;
        8'b100_00011: letter = LETTER_SPACE;
        8'b101_11111: letter = 6'd26;
        8'b101_01111: letter = 6'd27;
        8'b101_00111: letter = 6'd28;
        8'b101_00011: letter = 6'd29;
        8'b101_00001: letter = 6'd30;
        8'b101_00000: letter = 6'd31;
        8'b101_10000: letter = 6'd32;
        8'b101_11000: letter = 6'd33;
        8'b101_11100: letter = 6'd34;
        8'b101_11110: letter = 6'd35;
        default:      letter = LETTER_INVALID;
      endcase
    end
  end
endmodule

// File: rtl/morse_letter_decoder.sv
// Symbol assembler FSM feeding a letter FIFO with valid/ready output and
// registered error pulses for bad codes and overruns.
module morse_letter_decoder
  import morse_pkg::*;
#(
  parameter int MAX_SYMS = 6,
  parameter int DEPTH    = 4
) (
  input logic                  clk,
  input logic                  rst,
  morse_letter_decoder_if.slave bus
);
  localparam int LW = $clog2(MAX_SYMS + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LEN_MAX = MAX_SYMS[LW-1:0];
  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];

  state_t              state, state_nx;
  logic [LW-1:0]       len, len_nx;
  logic [MAX_SYMS-1:0] pat, pat_nx;
  logic                ovf, ovf_nx;
  push_t               push;
  logic [5:0]          lut_code;
  logic                fire;

  morse_lut #(.MAX_SYMS(MAX_SYMS)) u_lut (.len(len), .pattern(pat), .letter(lut_code));

  assign bus.sym_ready = (state != ST_SPACE_PEND);
  assign fire          = bus.sym_valid && bus.sym_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      len   <= '0;
      pat   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      len   <= len_nx;
      pat   <= pat_nx;
      ovf   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    len_nx   = len;
    pat_nx   = pat;
    ovf_nx   = ovf;
    push     = '0;
    if (state == ST_SPACE_PEND) begin
      push     = '{vld: 1'b1, code: LETTER_SPACE};
      state_nx = ST_IDLE;
    end else if (fire) begin
      if (bus.sym == SYM_DIT || bus.sym == SYM_DAH) begin
        // Extra symbols past MAX_SYMS only poison the letter; pattern is frozen.
        if (len == LEN_MAX) begin
          ovf_nx = 1'b1;
        end else begin
          pat_nx = {pat[MAX_SYMS-2:0], bus.sym == SYM_DAH};
          len_nx = len + 1'b1;
        end
        state_nx = ST_COLLECT;
      end else if (state == ST_COLLECT) begin
        push     = '{vld: 1'b1, code: ovf ? LETTER_INVALID : lut_code};
        len_nx   = '0;
        pat_nx   = '0;
        ovf_nx   = 1'b0;
        state_nx = (bus.sym == SYM_EOW) ? ST_SPACE_PEND : ST_IDLE;
      end else if (bus.sym == SYM_EOW) begin
        push = '{vld: 1'b1, code: LETTER_SPACE};
      end
    end
  end

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, wr, drop;

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign pop  = (count != '0) && bus.letter_ready;
  assign wr   = push.vld && ((count != FULL_LVL) || pop);
  assign drop = push.vld && !wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.err_code <= 1'b0;
      bus.err_drop <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= push.code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bus.err_code <= push.vld && (push.code == LETTER_INVALID);
      bus.err_drop <= drop;
    end
  end

  assign bus.letter       = mem[rd_ptr];
  assign bus.letter_valid = (count != '0);
  assign bus.level        = count;
endmodule

// File: tb/tb_morse_letter_decoder.sv
// Directed and randomized checks of the Morse letter decoder against a
// string/queue reference model.
module tb_morse_letter_decoder;
  import morse_pkg::*;
  localparam int MAX_SYMS = 6;
  localparam int DEPTH    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morse_letter_decoder_if #(.DEPTH(DEPTH)) bus ();
  morse_letter_decoder #(.MAX_SYMS(MAX_SYMS), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                        "---..", "----."};

  // Reference model: symbols so far as a string, a pending-space flag, a letter queue.
  string cur;
  bit    spc_pend;
  int    q[$];
  bit    exp_ec, exp_ed;

  function automatic int decode(string s);
    if (s.len() > MAX_SYMS) return 63;
    if (s == "..--") return 36;
    for (int i = 0; i < 36; i++) if (codes[i] == s) return i;
    return 63;
  endfunction

  function automatic void model_reset();
    cur = ""; spc_pend = 0; q.delete(); exp_ec = 0; exp_ed = 0;
  endfunction

  function automatic void model_edge();
    int pv = -1;
    bit pop = (q.size() > 0) && bus.letter_ready;
    if (spc_pend) begin
      pv = 36; spc_pend = 0;
    end else if (bus.sym_valid) begin
      case (bus.sym)
        SYM_DIT: cur = {cur, "."};
        SYM_DAH: cur = {cur, "-"};
        SYM_EOL: if (cur != "") begin pv = decode(cur); cur = ""; end
        default: if (cur != "") begin pv = decode(cur); cur = ""; spc_pend = 1; end
                 else pv = 36;
      endcase
    end
    if (pop) void'(q.pop_front());
    exp_ec = (pv == 63);
    exp_ed = 0;
    if (pv >= 0) begin
      if (q.size() < DEPTH) q.push_back(pv);
      else exp_ed = 1;
    end
  endfunction

  function automatic logic [1:0] sym_of(byte c);
    if (c == ".") return SYM_DIT;
    if (c == "-") return SYM_DAH;
    if (c == "/") return SYM_EOW;
    return SYM_EOL;
  endfunction

  task automatic step(input bit v, input logic [1:0] s, input bit r);
    bus.sym_valid = v; bus.sym = s; bus.letter_ready = r;
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, SYM_DIT, 1'b1);
  endtask

  task automatic test_reset();
    bus.sym_valid = 0; bus.sym = SYM_DIT; bus.letter_ready = 0;
    rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.letter_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b want 0", bus.letter_valid); end
    checks++; if (bus.letter !== 6'd0) begin failures++; $display("FAIL reset_letter got %0d want 0", bus.letter); end
    checks++; if (bus.level !== '0) begin failures++; $display("FAIL reset_level got %0d want 0", bus.level); end
    checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %0b want 1", bus.sym_ready); end
    checks++; if ({bus.err_code, bus.err_drop} !== 2'b00) begin failures++; $display("FAIL reset_err got %b want 00", {bus.err_code, bus.err_drop}); end
    rst = 0;
  endtask

  task automatic test_hello_world();
    string stim = " .... . .-.. .-.. --- ..-- .-- --- .-. .-.. -.. ";
    int exp_l[11] = '{7, 4, 11, 11, 14, 36, 22, 14, 17, 11, 3};
    int got[$];
    for (int i = 0; i < stim.len() + 2; i++) begin
      if (i < stim.len()) step(1'b1, sym_of(stim[i]), 1'b1);
      else idle(1);
      checks++; if ({bus.err_code, bus.err_drop} !== 2'b00) begin failures++; $display("FAIL hello_err got %b want 00", {bus.err_code, bus.err_drop}); end
      if (bus.letter_valid) got.push_back(int'(bus.letter));
    end
    checks++; if (got.size() !== 11) begin failures++; $display("FAIL hello_count got %0d want 11", got.size()); end
    for (int i = 0; i < 11 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_l[i]) begin failures++; $display("FAIL hello_letter[%0d] got %0d want %0d", i, got[i], exp_l[i]); end
    end
  endtask

  task automatic test_overflow();
    string stim = "....... ";
    idle(2);
    for (int i = 0; i < stim.len(); i++) step(1'b1, sym_of(stim[i]), 1'b1);
    checks++; if (bus.err_code !== 1'b1) begin failures++; $display("FAIL ovf_err_code got %0b want 1", bus.err_code); end
    checks++; if (bus.letter_valid !== 1'b1 || bus.letter !== LETTER_INVALID) begin failures++; $display("FAIL ovf_letter got v=%0b %0d want v=1 63", bus.letter_valid, bus.letter); end
    step(1'b1, SYM_DIT, 1'b1);
    checks++; if (bus.err_code !== 1'b0) begin failures++; $display("FAIL ovf_pulse_len got %0b want 0", bus.err_code); end
    step(1'b1, SYM_EOL, 1'b1);
    checks++; if (bus.letter_valid !== 1'b1 || bus.letter !== 6'd4) begin failures++; $display("FAIL ovf_after got v=%0b %0d want v=1 4", bus.letter_valid, bus.letter); end
  endtask

  task automatic test_fifo_full();
    idle(2);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, SYM_DIT, 1'b0);
      step(1'b1, SYM_EOL, 1'b0);
      checks++; if (int'(bus.level) !== q.size()) begin failures++; $display("FAIL full_level[%0d] got %0d want %0d", k, bus.level, q.size()); end
      checks++; if (bus.err_drop !== exp_ed) begin failures++; $display("FAIL full_drop[%0d] got %0b want %0b", k, bus.err_drop, exp_ed); end
    end
    checks++; if (bus.level !== 3'd4 || bus.err_drop !== 1'b1) begin failures++; $display("FAIL full_end got level=%0d drop=%0b want 4 1", bus.level, bus.err_drop); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.letter_valid !== 1'b1 || bus.letter !== 6'd4) begin failures++; $display("FAIL drain[%0d] got v=%0b %0d want v=1 4", k, bus.letter_valid, bus.letter); end
      idle(1);
    end
    checks++; if (bus.letter_valid !== 1'b0 || bus.level !== '0) begin failures++; $display("FAIL drain_empty got v=%0b level=%0d want 0 0", bus.letter_valid, bus.level); end
  endtask

  task automatic test_space_pend();
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b1, SYM_DIT, 1'b1);
    step(1'b1, SYM_EOW, 1'b1);
    checks++; if (bus.letter_valid !== 1'b1 || bus.letter !== 6'd18) begin failures++; $display("FAIL eow_letter got v=%0b %0d want v=1 18", bus.letter_valid, bus.letter); end
    checks++; if (bus.sym_ready !== 1'b0) begin failures++; $display("FAIL eow_bubble got %0b want 0", bus.sym_ready); end
    step(1'b1, SYM_DAH, 1'b1);
    checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL eow_ready_back got %0b want 1", bus.sym_ready); end
    checks++; if (bus.letter_valid !== 1'b1 || bus.letter !== LETTER_SPACE) begin failures++; $display("FAIL eow_space got v=%0b %0d want v=1 36", bus.letter_valid, bus.letter); end
    step(1'b1, SYM_DAH, 1'b1);
    step(1'b1, SYM_EOL, 1'b1);
    checks++; if (bus.letter_valid !== 1'b1 || bus.letter !== 6'd19) begin failures++; $display("FAIL eow_held got v=%0b %0d want v=1 19", bus.letter_valid, bus.letter); end
  endtask

  task automatic test_full_pop_push();
    int picks[$];
    idle(2);
    for (int k = 0; k < 4; k++) begin
      int p = int'($urandom_range(0, 35));
      string s = {codes[p], " "};
      picks.push_back(p);
      for (int i = 0; i < s.len(); i++) step(1'b1, sym_of(s[i]), 1'b0);
    end
    picks.push_back(4);
    step(1'b1, SYM_DIT, 1'b0);
    step(1'b1, SYM_EOL, 1'b1);
    checks++; if (bus.level !== 3'd4 || bus.err_drop !== 1'b0) begin failures++; $display("FAIL popush got level=%0d drop=%0b want 4 0", bus.level, bus.err_drop); end
    for (int k = 1; k < 5; k++) begin
      checks++; if (bus.letter_valid !== 1'b1 || int'(bus.letter) !== picks[k]) begin failures++; $display("FAIL popush_order[%0d] got v=%0b %0d want v=1 %0d", k, bus.letter_valid, bus.letter, picks[k]); end
      idle(1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int r = int'($urandom_range(0, 7));
      logic [1:0] s = (r < 3) ? SYM_DIT : (r < 6) ? SYM_DAH : (r == 6) ? SYM_EOL : SYM_EOW;
      step(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 9) < 7));
      checks++; if (bus.sym_ready !== !spc_pend) begin failures++; $display("FAIL rnd_ready[%0d] got %0b want %0b", n, bus.sym_ready, !spc_pend); end
      checks++; if (int'(bus.level) !== q.size()) begin failures++; $display("FAIL rnd_level[%0d] got %0d want %0d", n, bus.level, q.size()); end
      checks++; if (bus.letter_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, bus.letter_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (int'(bus.letter) !== q[0]) begin failures++; $display("FAIL rnd_letter[%0d] got %0d want %0d", n, bus.letter, q[0]); end
      end
      checks++; if (bus.err_code !== exp_ec || bus.err_drop !== exp_ed) begin failures++; $display("FAIL rnd_err[%0d] got %b want %b", n, {bus.err_code, bus.err_drop}, {exp_ec, exp_ed}); end
    end
  endtask

  task automatic test_reset_mid();
    string stim = ". - -.";
    idle(3);
    for (int i = 0; i < stim.len(); i++) step(1'b1, sym_of(stim[i]), 1'b0);
    checks++; if (bus.level !== 3'd2) begin failures++; $display("FAIL rstmid_pre got level=%0d want 2", bus.level); end
    #2 rst = 1; model_reset();
    #1;
    checks++; if (bus.letter_valid !== 1'b0 || bus.level !== '0 || bus.letter !== 6'd0) begin failures++; $display("FAIL rstmid_async got v=%0b level=%0d letter=%0d want 0 0 0", bus.letter_valid, bus.level, bus.letter); end
    checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got %0b want 1", bus.sym_ready); end
    @(posedge clk); #1 rst = 0;
    step(1'b1, SYM_DIT, 1'b1);
    step(1'b1, SYM_EOL, 1'b1);
    checks++; if (bus.letter_valid !== 1'b1 || bus.letter !== 6'd4 || bus.level !== 3'd1) begin failures++; $display("FAIL rstmid_post got v=%0b %0d level=%0d want 1 4 1", bus.letter_valid, bus.letter, bus.level); end
    idle(1);
    checks++; if (bus.letter_valid !== 1'b0) begin failures++; $display("FAIL rstmid_only got v=%0b want 0", bus.letter_valid); end
  endtask

  initial begin
    test_reset();
    test_hello_world();
    test_overflow();
    test_fifo_full();
    test_space_pend();
    test_full_pop_push();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
